mig_tt_sweep: RTL
=================

Name: mig_tt_sweep

Overview:
- Programmable majority-inverter-graph (MIG) evaluator for NUM_IN-input Boolean functions.
- Holds a small netlist of NUM_GATES 3-input majority gates with per-operand inversion.
- On start, sweeps all 2^NUM_IN input vectors at one vector per clock and assembles the full truth table of the selected output node.
- Sits beside the fixed-function classification netlists and generates or checks their truth-table signatures in hardware.

Parameters:
- NUM_IN, 7, number of primary inputs x0..x{NUM_IN-1}; legal range 2..10.
- NUM_GATES, 8, number of majority gates; legal range 1..32.
- SEL_W, $clog2(1+NUM_IN+NUM_GATES), node-index width (derived; do not override).
- TT_W, 2**NUM_IN, truth-table width (derived).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- cfg_we  in  1  configuration write strobe.
- cfg_gate  in  $clog2(NUM_GATES+1)  gate index; value NUM_GATES addresses the output selector.
- cfg_op  in  2  operand slot 0..2; ignored for the output selector; value 3 is illegal.
- cfg_sel  in  SEL_W  source node index.
- cfg_inv  in  1  complement the source node.
- cfg_err  out  1  one-cycle pulse when a write is rejected.
- start  in  1  begin a sweep.
- abort  in  1  cancel a running sweep.
- busy  out  1  sweep in progress.
- done  out  1  one-cycle pulse when a sweep completes.
- tt_valid  out  1  tt holds a complete table.
- tt  out  TT_W  truth table; bit v is the output for input vector v, with x0 as the LSB of v.

Behaviour:
- Node numbering:
  - 0 is constant 0.
  - 1..NUM_IN are x0..x{NUM_IN-1}.
  - NUM_IN+1+g is gate g.
- Gate g output is maj(a,b,c), where each operand is the selected node XOR its inv bit.
- Operand reads:
  - An operand referencing gate h >= g reads as 0 (no combinational loops; netlists must be topologically ordered).
  - An index above the last node reads as 0.
- Output value is the selected node XOR out_inv.
- The whole network is evaluated combinationally within one cycle from the vector counter.
- Reset (asynchronous):
  - All operand selects, invs, out_sel and out_inv cleared.
  - State IDLE, counter 0, tt = 0.
  - tt_valid, busy, done and cfg_err all 0.
- Config writes:
  - Accepted only in IDLE; take effect on the next edge.
  - A write in SWEEP, or with cfg_op = 3 while cfg_gate < NUM_GATES, or with cfg_gate > NUM_GATES, is dropped and pulses cfg_err on the following cycle.
- State IDLE (busy = 0):
  - start = 1 moves to SWEEP.
  - On the same edge: counter <= 0, tt_valid <= 0, tt <= 0.
- State SWEEP (busy = 1):
  - Each cycle, tt[counter] <= out_value and counter increments.
  - When counter = TT_W-1, the bit is written, the state returns to IDLE, done pulses for one cycle and tt_valid <= 1.
  - Sweep duration is exactly TT_W cycles; done is high in the cycle TT_W+1 after start was sampled.
- abort in SWEEP:
  - Returns to IDLE on that edge; the current bit is not written.
  - tt_valid stays 0, done is not pulsed, and the partial tt is retained but not valid.
  - abort has priority over completion on the final vector.
- start while in SWEEP is ignored. abort while in IDLE is ignored.
- Simultaneous start and cfg_we in IDLE: the write is accepted and the sweep uses the new config.
- tt and tt_valid hold until the next start or reset.
- Reset asserted mid-sweep: immediate return to reset values; the config is also lost.

Decomposition:
- Package mig_pkg holds:
  - node-index constants (NODE_CONST0, NODE_X0, node_gate(g) function);
  - an operand struct {sel, inv};
  - a gate struct of 3 operands;
  - the state enum {IDLE, SWEEP}.
- One sub-module, mig_eval: purely combinational network evaluator. It takes the vector, config array and output selector, and returns out_value. It is reused by the fixed classification netlists for equivalence checks.

Test Plan:
- Reset, then start with no config -> done 129 cycles after start, tt = 128'h0, tt_valid = 1.
- Program gate0 = maj(x0,x1,x2), out = gate0; start -> tt = 128'hE8E8_E8E8_..._E8E8 (16 bytes of E8).
- Program g0 = maj(x0,x1,x5), g1 = maj(x0,x2,x4), g2 = maj(x1,x2,x3), g3 = maj(x3,x6,g2), g4 = maj(g0,g1,g3), out = g4 -> tt = 128'hfeeaeee0fac8a880feeaeca0f888a880.
- out_sel = 0 with out_inv = 1 -> tt all ones. Gate0 operand referencing gate1 with gate0 = maj(that,x0,x1) -> behaves as maj(0,x0,x1) = AND, tt = 128'h8888...8888.
- Start, then at sweep cycle 50 drive cfg_we -> config unchanged and cfg_err pulses; then abort -> busy 0, no done, tt_valid 0.
- Assert rst at sweep cycle 100 -> all outputs 0 asynchronously; the next start with the same program yields the all-zero table.

Source files
------------

// File: rtl/mig_pkg.sv
// Shared types and helpers for the majority-inverter-graph evaluator.
// Node indices use one fixed width so every parameterisation shares the same structs.
package mig_pkg;

    localparam int MAX_SEL_W  = 6;
    localparam int NODE_SPACE = 2 ** MAX_SEL_W;

    localparam logic [MAX_SEL_W-1:0] NODE_CONST0 = 6'd0;
    localparam logic [MAX_SEL_W-1:0] NODE_X0     = 6'd1;

    typedef struct packed {
        logic [MAX_SEL_W-1:0] sel;
        logic                 inv;
    } operand_t;

    typedef struct packed {
        operand_t [2:0] ops;
    } gate_t;

    typedef enum logic {
        IDLE  = 1'b0,
        SWEEP = 1'b1
    } state_t;

    function automatic logic [MAX_SEL_W-1:0] node_gate(input int numIn, input int g);
        return MAX_SEL_W'(numIn + 1 + g);
    endfunction

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/mig_eval.sv
// Purely combinational MIG network evaluator: one input vector in, selected node value out.
// Also used standalone beside the fixed classification netlists for equivalence checks.
module mig_eval
    import mig_pkg::*;
#(
    parameter int NUM_IN    = 7,
    parameter int NUM_GATES = 8
) (
    input  logic [NUM_IN-1:0] vec,
    input  gate_t             gates [NUM_GATES],
    input  operand_t          outSel,
    output logic              out_value
);

    logic [NODE_SPACE-1:0] nodes;
    logic [2:0]            opVal;

    // Nodes outside the populated range stay 0, so an out-of-range output select reads 0.
    // A gate may only see strictly earlier nodes; later gates read as 0, keeping the net acyclic.
    always_comb begin
        nodes = '0;
        opVal = '0;
        nodes[NODE_CONST0]         = 1'b0;
        nodes[NODE_X0 +: NUM_IN]   = vec;
        for (int g = 0; g < NUM_GATES; g++) begin
            for (int k = 0; k < 3; k++) begin
                if (gates[g].ops[k].sel < node_gate(NUM_IN, g)) begin
                    opVal[k] = nodes[gates[g].ops[k].sel] ^ gates[g].ops[k].inv;
                end else begin
                    opVal[k] = gates[g].ops[k].inv;
                end
            end
            nodes[node_gate(NUM_IN, g)] = maj3(opVal[0], opVal[1], opVal[2]);
        end
        out_value = nodes[outSel.sel] ^ outSel.inv;
    end

endmodule

// File: rtl/mig_tt_sweep.sv
// Programmable MIG evaluator that sweeps every input vector, one per clock,
// and assembles the truth table of the selected output node.
module mig_tt_sweep
    import mig_pkg::*;
#(
    parameter int NUM_IN    = 7,
    parameter int NUM_GATES = 8,
    parameter int SEL_W     = $clog2(1 + NUM_IN + NUM_GATES),
    parameter int TT_W      = 2 ** NUM_IN
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             cfg_we,
    input  logic [$clog2(NUM_GATES+1)-1:0]   cfg_gate,
    input  logic [1:0]                       cfg_op,
    input  logic [SEL_W-1:0]                 cfg_sel,
    input  logic                             cfg_inv,
    output logic                             cfg_err,
    input  logic                             start,
    input  logic                             abort,
    output logic                             busy,
    output logic                             done,
    output logic                             tt_valid,
    output logic [TT_W-1:0]                  tt
);

    localparam int                GATE_W   = $clog2(NUM_GATES + 1);
    localparam logic [GATE_W-1:0] OUT_SLOT = GATE_W'(NUM_GATES);

    state_t            state;
    state_t            nextState;
    gate_t             gates [NUM_GATES];
    operand_t          outSel;
    operand_t          cfgOperand;
    logic [NUM_IN-1:0] counter;
    logic              outValue;
    logic              cfgAccept;
    logic              cfgReject;
    logic              writeBit;
    logic              finishSweep;

    assign cfgOperand = {MAX_SEL_W'(cfg_sel), cfg_inv};
    assign busy       = (state == SWEEP);

    mig_eval #(
        .NUM_IN    (NUM_IN),
        .NUM_GATES (NUM_GATES)
    ) u_eval (
        .vec       (counter),
        .gates     (gates),
        .outSel    (outSel),
        .out_value (outValue)
    );

    // Writes land only while idle, to a real gate slot with a real operand, or to the output selector.
    always_comb begin
        cfgAccept = 1'b0;
        if (cfg_we && state == IDLE) begin
            if (cfg_gate == OUT_SLOT) begin
                cfgAccept = 1'b1;
            end else if (cfg_gate < OUT_SLOT && cfg_op != 2'd3) begin
                cfgAccept = 1'b1;
            end
        end
    end

    assign cfgReject = cfg_we && !cfgAccept;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int g = 0; g < NUM_GATES; g++) begin
                gates[g] <= '0;
            end
            outSel  <= '0;
            cfg_err <= 1'b0;
        end else begin
            cfg_err <= cfgReject;
            if (cfgAccept) begin
                for (int g = 0; g < NUM_GATES; g++) begin
                    if (cfg_gate == GATE_W'(g)) begin
                        gates[g].ops[cfg_op] <= cfgOperand;
                    end
                end
                if (cfg_gate == OUT_SLOT) begin
                    outSel <= cfgOperand;
                end
            end
        end
    end

    // Abort wins over completion, so the last vector is never written once abort is seen.
    always_comb begin
        nextState   = state;
        writeBit    = 1'b0;
        finishSweep = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    nextState = SWEEP;
                end
            end
            SWEEP: begin
                if (abort) begin
                    nextState = IDLE;
                end else begin
                    writeBit = 1'b1;
                    if (counter == '1) begin
                        finishSweep = 1'b1;
                        nextState   = IDLE;
                    end
                end
            end
            default: nextState = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            counter  <= '0;
            tt       <= '0;
            tt_valid <= 1'b0;
            done     <= 1'b0;
        end else begin
            state <= nextState;
            done  <= finishSweep;
            if (state == IDLE && start) begin
                counter  <= '0;
                tt       <= '0;
                tt_valid <= 1'b0;
            end else if (writeBit) begin
                tt[counter] <= outValue;
                counter     <= counter + 1'b1;
            end
            if (finishSweep) begin
                tt_valid <= 1'b1;
            end
        end
    end

endmodule
